// File: rtl/dio_mem_sequencer.sv
// Bridges SPI data-interface toggle strobes onto one 16-bit memory port: buffered writes plus read prefetch.
// Writes reach memory after >=2 cycles plus memory latency; a full FIFO drops the write and sets overflow.

module dio_mem_fifo #(
  parameter int W    = 39,
  parameter int LOG2 = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);
  localparam int DEPTH = 1 << LOG2;

  logic [W-1:0]  store [DEPTH];
  logic [LOG2:0] wp;
  logic [LOG2:0] rp;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wp[LOG2] != rp[LOG2]) && (wp[LOG2-1:0] == rp[LOG2-1:0]);
  assign pop_vld = (wp != rp);
  assign pop_dat = store[rp[LOG2-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_vld && !full) wp <= wp + 1'b1;
      if (pop_rdy && pop_vld) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !full) store[wp[LOG2-1:0]] <= push_dat;
  end
endmodule

module dio_mem_sequencer #(
  parameter int FIFO_LOG2 = 2,
  parameter int AW        = 23
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_strobe_mist,
  input  logic          wr_strobe_uio,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] wr_addr,
  input  logic          addr_strobe,
  input  logic [31:0]   addr_reg,
  input  logic          rd_strobe,
  output logic [15:0]   rd_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ack,
  output logic          busy,
  output logic          overflow,
  output logic          underrun
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t        state;
  logic          armed;
  logic [3:0]    strb_cur;
  logic [3:0]    strb_prev;
  logic [3:0]    strb_ev;
  logic          ev_mist, ev_uio, ev_rd, ev_addr;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic          dir;
  logic          fetch_pend;
  logic          fetch_init;
  logic          drop;
  logic          rd_late;

  logic             fifo_push;
  logic [AW+15:0]   fifo_push_dat;
  logic             fifo_full;
  logic             fifo_vld;
  logic [AW+15:0]   fifo_head;
  logic             fifo_pop;

  // Sector count in addr_reg[31:24] is carried by the interface but not needed here.
  logic unused_sector;
  assign unused_sector = ^addr_reg[31:24];

  assign strb_cur = {addr_strobe, rd_strobe, wr_strobe_uio, wr_strobe_mist};
  assign strb_ev  = armed ? (strb_cur ^ strb_prev) : 4'b0000;
  assign ev_mist  = strb_ev[0];
  assign ev_uio   = strb_ev[1];
  assign ev_rd    = strb_ev[2];
  assign ev_addr  = strb_ev[3];

  // UIO wins a same-cycle collision; the MIST word is lost and flagged.
  assign fifo_push     = (ev_uio || ev_mist) && !fifo_full;
  assign fifo_push_dat = ev_uio ? {wr_addr, wr_data} : {ptr, wr_data};
  assign drop          = (ev_uio && ev_mist) || ((ev_uio || ev_mist) && fifo_full);
  assign rd_late       = ev_rd && dir && (fetch_pend || (state == RD));
  assign fifo_pop      = (state == WR) && mem_ack;

  always_comb begin
    ptr_nxt = ptr;
    if (ev_addr) ptr_nxt = AW'(addr_reg[22:0]);
    else         ptr_nxt = ptr + AW'(ev_mist) + AW'(ev_rd && dir);
  end

  assign busy = fifo_vld || fetch_pend || (state != IDLE);

  dio_mem_fifo #(
    .W    (AW + 16),
    .LOG2 (FIFO_LOG2)
  ) u_wr_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (fifo_push),
    .push_dat (fifo_push_dat),
    .full     (fifo_full),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_head),
    .pop_rdy  (fifo_pop)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      strb_prev  <= '0;
      ptr        <= '0;
      dir        <= 1'b0;
      fetch_pend <= 1'b0;
      fetch_init <= 1'b0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      rd_data    <= '0;
    end else begin
      armed     <= 1'b1;
      strb_prev <= strb_cur;
      ptr       <= ptr_nxt;
      overflow  <= (overflow && !ev_addr) || drop;
      underrun  <= (underrun && !ev_addr) || rd_late;
      if (ev_addr) dir <= addr_reg[23];

      case (state)
        IDLE: begin
          // The first fetch after an address command waits for queued writes to drain.
          if (fetch_pend && (!fifo_vld || !fetch_init)) begin
            state      <= RD;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= ptr;
            fetch_init <= 1'b0;
          end else if (fifo_vld) begin
            state    <= WR;
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= fifo_head[AW+15:16];
            mem_din  <= fifo_head[15:0];
          end
        end
        WR: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        RD: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            rd_data <= mem_dout;
            // A pointer move during the fetch leaves the prefetch pending for the new word.
            if (ptr == mem_addr) fetch_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (ev_addr) begin
        fetch_pend <= addr_reg[23];
        fetch_init <= addr_reg[23];
      end else if (ev_rd && dir) begin
        fetch_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dio_mem_sequencer.sv
// Directed bench: a memory responder serves requests, a monitor checks each new request against a queue
// of hand-computed expectations, and the stimulus thread checks rd_data, busy and the sticky flags.

module tb_dio_mem_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_strobe_mist, wr_strobe_uio, addr_strobe, rd_strobe;
  logic [15:0] wr_data;
  logic [22:0] wr_addr;
  logic [31:0] addr_reg;
  logic [15:0] rd_data;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ack;
  logic        busy, overflow, underrun;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [15:0] dat;
  } req_t;

  req_t        exp_q[$];
  req_t        mon_e;
  logic [15:0] mem_model [int];
  logic        req_q    = 1'b0;
  logic        ack_hold = 1'b0;
  int          ack_lat  = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  dio_mem_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_strobe_mist (wr_strobe_mist),
    .wr_strobe_uio  (wr_strobe_uio),
    .wr_data        (wr_data),
    .wr_addr        (wr_addr),
    .addr_strobe    (addr_strobe),
    .addr_reg       (addr_reg),
    .rd_strobe      (rd_strobe),
    .rd_data        (rd_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .overflow       (overflow),
    .underrun       (underrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic expect_req(input logic we, input logic [22:0] a, input logic [15:0] d);
    req_t r;
    r.we   = we;
    r.addr = a;
    r.dat  = d;
    exp_q.push_back(r);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m = {addr, rd, uio, mist}; data/address are applied in the same step as the toggle.
  task automatic drive(input logic [3:0] m, input logic [15:0] d, input logic [22:0] ua,
                       input logic [31:0] ar);
    @(posedge clk);
    #1;
    wr_data  = d;
    wr_addr  = ua;
    addr_reg = ar;
    if (m[0]) wr_strobe_mist = ~wr_strobe_mist;
    if (m[1]) wr_strobe_uio  = ~wr_strobe_uio;
    if (m[2]) rd_strobe      = ~rd_strobe;
    if (m[3]) addr_strobe    = ~addr_strobe;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 400);
    chk(nm, busy, 0);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!mem_req && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, mem_req, 1);
  endtask

  // Memory responder: ack after ack_lat waiting cycles unless held.
  initial begin
    mem_ack  = 1'b0;
    mem_dout = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && !ack_hold) begin
        if (wait_cnt >= ack_lat) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem_model[int'(mem_addr)] = mem_din;
          else mem_dout = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 16'h0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every newly raised request must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mem_req && !req_q) begin
      chk("req_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("req_we", mem_we, mon_e.we);
        chk("req_addr", mem_addr, mon_e.addr);
        if (mon_e.we) chk("req_din", mem_din, mon_e.dat);
      end
    end
    req_q = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    wr_strobe_mist = 1'b1;
    wr_strobe_uio  = 1'b0;
    addr_strobe    = 1'b0;
    rd_strobe      = 1'b0;
    wr_data        = 16'h0;
    wr_addr        = 23'h0;
    addr_reg       = 32'h0;
    mem_model[32'h40] = 16'hBEEF;
    mem_model[32'h41] = 16'hCAFE;
    mem_model[32'h60] = 16'h1234;
    mem_model[32'h61] = 16'h5678;
    mem_model[32'h62] = 16'h9ABC;

    cyc(3);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    cyc(3);
    chk("release_no_push", busy, 0);

    // 1: pointer-addressed MIST writes
    drive(4'b1000, 16'h0, 23'h0, 32'h0000_0100);
    expect_req(1'b1, 23'h100, 16'h1111);
    drive(4'b0001, 16'h1111, 23'h0, 32'h0000_0100);
    expect_req(1'b1, 23'h101, 16'h2222);
    drive(4'b0001, 16'h2222, 23'h0, 32'h0000_0100);
    expect_req(1'b1, 23'h102, 16'h3333);
    drive(4'b0001, 16'h3333, 23'h0, 32'h0000_0100);
    wait_idle("t1_idle");
    expect_req(1'b1, 23'h103, 16'h4444);
    drive(4'b0001, 16'h4444, 23'h0, 32'h0000_0100);
    wait_idle("t1_ptr_idle");

    // 2: read prefetch and advance
    expect_req(1'b0, 23'h40, 16'h0);
    drive(4'b1000, 16'h0, 23'h0, 32'h0080_0040);
    wait_idle("t2_idle_a");
    chk("t2_rd_first", rd_data, 16'hBEEF);
    expect_req(1'b0, 23'h41, 16'h0);
    drive(4'b0100, 16'h0, 23'h0, 32'h0080_0040);
    wait_idle("t2_idle_b");
    chk("t2_rd_next", rd_data, 16'hCAFE);
    chk("t2_underrun", underrun, 0);

    // 3: FIFO overflow with ack withheld
    ack_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_req(1'b1, 23'h700000 + 23'(i), 16'hA000 + 16'(i));
      drive(4'b0010, 16'hA000 + 16'(i), 23'h700000 + 23'(i), 32'h0080_0040);
    end
    cyc(2);
    chk("t3_overflow", overflow, 1);
    chk("t3_busy_held", busy, 1);
    ack_hold = 1'b0;
    wait_idle("t3_idle");
    drive(4'b1000, 16'h0, 23'h0, 32'h0000_0000);
    cyc(1);
    chk("t3_overflow_clr", overflow, 0);

    // 4: first read deferred behind pending writes
    ack_lat = 5;
    drive(4'b1000, 16'h0, 23'h0, 32'h0000_0200);
    expect_req(1'b1, 23'h200, 16'h5551);
    drive(4'b0001, 16'h5551, 23'h0, 32'h0000_0200);
    expect_req(1'b1, 23'h201, 16'h5552);
    drive(4'b0001, 16'h5552, 23'h0, 32'h0000_0200);
    expect_req(1'b1, 23'h202, 16'h5553);
    drive(4'b0001, 16'h5553, 23'h0, 32'h0000_0200);
    expect_req(1'b0, 23'h40, 16'h0);
    drive(4'b1000, 16'h0, 23'h0, 32'h0080_0040);
    chk("t4_busy", busy, 1);
    wait_idle("t4_idle");
    chk("t4_rd_after_writes", rd_data, 16'hBEEF);

    // 5: two advances during one outstanding fetch
    expect_req(1'b0, 23'h60, 16'h0);
    drive(4'b1000, 16'h0, 23'h0, 32'h0080_0060);
    wait_req("t5_req");
    drive(4'b0100, 16'h0, 23'h0, 32'h0080_0060);
    drive(4'b0100, 16'h0, 23'h0, 32'h0080_0060);
    expect_req(1'b0, 23'h62, 16'h0);
    wait_idle("t5_idle");
    chk("t5_underrun", underrun, 1);
    chk("t5_rd_data", rd_data, 16'h9ABC);

    // 6: reset while a request is outstanding
    ack_lat  = 0;
    ack_hold = 1'b1;
    expect_req(1'b1, 23'h10, 16'hD001);
    drive(4'b0010, 16'hD001, 23'h10, 32'h0080_0060);
    drive(4'b0011, 16'hD002, 23'h11, 32'h0080_0060);
    wait_req("t6_req");
    cyc(1);
    chk("t6_overflow_pre", overflow, 1);
    chk("t6_underrun_pre", underrun, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_mem_req", mem_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_underrun", underrun, 0);
    ack_hold = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(6);
    chk("t6_busy_after", busy, 0);
    chk("t6_req_after", mem_req, 0);
    chk("exp_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dio_mem_sequencer.md
Name: dio_mem_sequencer

Overview:
- Sits between the SPI data-interface block and the single 16-bit system memory port, in the `clk` domain.
- Turns the interface's toggle strobes into word writes and read prefetches on that port:
  - MIST memory writes and reads use an auto-incrementing word pointer loaded by the address command.
  - UIO file-download writes use the address supplied with each word.
- Buffers writes in a small FIFO and arbitrates the port between the write drain and the read prefetch.

Parameters:
FIFO_LOG2, 2, log2 of write FIFO depth (default 4 entries)
AW, 23, word-address width (bits 23:1 of byte address)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_strobe_mist  in  1  toggle: wr_data valid for MIST write (pointer address)
wr_strobe_uio  in  1  toggle: wr_data valid for UIO download (address wr_addr)
wr_data  in  16  write word
wr_addr  in  AW  UIO word address
addr_strobe  in  1  toggle: addr_reg updated
addr_reg  in  32  [31:24] sector count (unused), [23] direction (1 = read), [22:0] word address
rd_strobe  in  1  toggle: current rd_data consumed, advance
rd_data  out  16  word at read pointer, to SPI transmitter
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  AW  request word address
mem_din  out  16  write data
mem_dout  in  16  read data, valid in mem_ack cycle
mem_ack  in  1  one-cycle completion pulse
busy  out  1  FIFO non-empty, fetch pending, or request active
overflow  out  1  sticky: write dropped (FIFO full or collision)
underrun  out  1  sticky: rd_strobe arrived while previous fetch outstanding

Behaviour:
- Reset: all outputs 0; pointer 0, FIFO empty, state IDLE; flags cleared. Asserting reset mid-request drops mem_req immediately; the memory side tolerates an abandoned request.
- Toggle detection:
  - Each strobe input has a previous-value register; an event is cur XOR prev.
  - An `armed` bit is clear after reset. The first clk edge after reset release copies all four inputs into prev and sets `armed`, so no event is generated on that edge.
- addr_strobe event:
  - ptr <= addr_reg[22:0]; overflow and underrun are cleared; dir <= addr_reg[23].
  - If dir = 1, a first fetch (fetch_pend) is queued. It is deferred until the FIFO is empty, so earlier writes land first.
- Write push:
  - wr_strobe_mist event: push {ptr, wr_data}, ptr <= ptr+1 (wraps at 2^AW).
  - wr_strobe_uio event: push {wr_addr, wr_data}.
  - Both in the same cycle: UIO pushed, MIST dropped, overflow set.
  - FIFO full: the entry is dropped and overflow set. A pop in the same cycle does not free the slot for that push.
- rd_strobe event (dir = 1): ptr <= ptr+1 and fetch_pend set for the new pointer. If a fetch is already pending or active, underrun is set and the fetch is still re-targeted to the latest ptr.
- Arbiter FSM, states IDLE / WR / RD:
  - IDLE: if fetch_pend and FIFO empty-or-not-initial-fetch → RD. Else if FIFO non-empty → WR. Read has priority except for the deferred first fetch.
  - On entry to WR or RD, mem_req=1 with mem_we/mem_addr/mem_din registered and stable until ack.
  - WR: on mem_ack, pop FIFO, mem_req=0, → IDLE.
  - RD: on mem_ack, rd_data <= mem_dout, clear fetch_pend unless ptr changed meanwhile, mem_req=0, → IDLE.
  - There is at least one idle cycle between requests. mem_ack while in IDLE is ignored.
- rd_data holds its value except on a read ack.
- busy is combinational from FIFO count, fetch_pend and state.
- FIFO: circular buffer, FIFO_LOG2+1-bit pointers; full/empty come from pointer MSB compare.

Test Plan:
1. Reset release with wr_strobe_mist=1 and other strobes 0 → no push. Then addr_strobe toggle with addr_reg=0x00000100 plus three MIST toggles (data 0x1111, 0x2222, 0x3333) → writes to 0x100, 0x101, 0x102 in order; ptr ends at 0x103.
2. addr_reg=0x00800040 (read) with memory at 0x40=0xBEEF and 0x41=0xCAFE → rd_data=0xBEEF after ack. One rd_strobe toggle → rd_data=0xCAFE; underrun stays 0.
3. mem_ack withheld and 6 UIO toggles (addresses 0x700000 upward) → first 4 accepted, 2 dropped, overflow=1. On release, exactly 4 writes occur; next addr_strobe clears overflow.
4. Three writes pending with mem_ack delayed 5 cycles, then addr_strobe read → all 3 writes complete before the first read request (mem_we=0). busy=1 throughout, then 0.
5. Two rd_strobe toggles within one outstanding fetch → underrun=1; final rd_data equals word at ptr+2.
6. reset_n low while mem_req=1 → mem_req, busy, rd_data and flags 0 in the same cycle; FIFO empty after release.
